// File: rtl/soc_mem_fabric.sv
// Memory fabric for the PicoRV32 native bus: byte-writable RAM, loader-writable program
// memory, windowed IO channels with timeout, and a sticky bus-error status register.
module soc_mem_fabric #(
  parameter int          RAM_WORDS   = 8192,
  parameter int          PROG_WORDS  = 4096,
  parameter logic [31:0] PROG_BASE   = 32'h0010_0000,
  parameter int          IO_CH       = 4,
  parameter logic [31:0] IO_BASE     = 32'h0300_0000,
  parameter int          IO_WIN_LOG2 = 20,
  parameter logic [31:0] STAT_ADDR   = 32'h0200_0010,
  parameter int          TIMEOUT     = 255
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cpu_valid,
  input  logic                    cpu_instr,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_wstrb,
  output logic                    cpu_ready,
  output logic [31:0]             cpu_rdata,
  output logic [IO_CH-1:0]        io_valid,
  output logic [IO_WIN_LOG2-1:0]  io_addr,
  output logic [31:0]             io_wdata,
  output logic [3:0]              io_wstrb,
  input  logic [IO_CH-1:0]        io_ready,
  input  logic [32*IO_CH-1:0]     io_rdata,
  input  logic                    ld_wen,
  input  logic [31:0]             ld_waddr,
  input  logic [31:0]             ld_wdata,
  output logic                    err_irq,
  output logic [31:0]             err_addr
);

  localparam int          RAM_AW     = $clog2(RAM_WORDS);
  localparam int          PROG_AW    = $clog2(PROG_WORDS);
  localparam int          CH_W       = (IO_CH > 1) ? $clog2(IO_CH) : 1;
  localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS) << 2;
  localparam logic [31:0] PROG_BYTES = 32'(PROG_WORDS) << 2;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_IO_WAIT, S_RESP} state_t;
  typedef enum logic [2:0] {R_RAM, R_PROG, R_STAT, R_IO, R_UNMAP} region_t;

  state_t            r_state, w_state_nxt;
  region_t           r_region, w_dec_region;
  logic [CH_W-1:0]   r_ch, w_dec_ch;
  logic [IO_CH-1:0]  w_dec_onehot;
  logic [31:0]       r_addr, r_wdata, r_rdata, r_err_addr;
  logic [3:0]        r_wstrb;
  logic [15:0]       r_cnt;
  logic [IO_CH-1:0]  r_io_valid;
  logic              r_cpu_ready, r_err_irq;
  logic              w_done, w_err_set, w_err_clr, w_ram_we, w_io_start, w_io_end;
  logic [31:0]       w_rdata_nxt;

  logic [31:0]       r_ram  [RAM_WORDS];
  logic [31:0]       r_prog [PROG_WORDS];
  logic [31:0]       r_ram_q, r_prog_q;

  logic [31:0]       w_prog_off, w_io_off, w_io_page;
  logic [31:0]       w_rd_addr, w_prog_roff;
  logic [RAM_AW-1:0] w_ram_ridx, w_ram_widx;
  logic [PROG_AW-1:0] w_prog_ridx, w_ld_idx;
  logic              w_ld_hit;
  logic              w_unused;

  assign w_prog_off = cpu_addr - PROG_BASE;
  assign w_io_off   = cpu_addr - IO_BASE;
  assign w_io_page  = w_io_off >> IO_WIN_LOG2;

  // Address decode in priority order; the first matching region wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_dec_region = R_UNMAP;
    w_dec_ch     = '0;
    if (cpu_addr < RAM_BYTES) begin
      w_dec_region = R_RAM;
    end else if (cpu_addr >= PROG_BASE && w_prog_off < PROG_BYTES) begin
      w_dec_region = R_PROG;
    end else if (cpu_addr == STAT_ADDR) begin
      w_dec_region = R_STAT;
    end else if (cpu_addr >= IO_BASE && w_io_page < 32'(IO_CH)) begin
      w_dec_region = R_IO;
      w_dec_ch     = w_io_page[CH_W-1:0];
    end
  end

  always_comb begin
    for (int k = 0; k < IO_CH; k++) w_dec_onehot[k] = (w_dec_ch == CH_W'(k));
  end

  // Memories read every cycle; in IDLE the live CPU address is used so data is ready in MEM.
  assign w_rd_addr   = (r_state == S_IDLE) ? cpu_addr : r_addr;
  assign w_prog_roff = w_rd_addr - PROG_BASE;
  assign w_ram_ridx  = w_rd_addr[RAM_AW+1:2];
  assign w_ram_widx  = r_addr[RAM_AW+1:2];
  assign w_prog_ridx = w_prog_roff[PROG_AW+1:2];
  assign w_ld_hit    = ld_wen && (ld_waddr < PROG_BYTES);
  assign w_ld_idx    = ld_waddr[PROG_AW+1:2];
  assign w_unused    = &{1'b0, cpu_instr, w_prog_roff};

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_rdata_nxt = r_rdata;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    w_ram_we    = 1'b0;
    w_io_start  = 1'b0;
    w_io_end    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_valid) begin
          if (w_dec_region == R_IO) begin
            w_state_nxt = S_IO_WAIT;
            w_io_start  = 1'b1;
          end else begin
            w_state_nxt = S_MEM;
          end
        end
      end
      S_MEM: begin
        case (r_region)
          R_RAM: begin
            w_done      = 1'b1;
            w_rdata_nxt = r_ram_q;
            w_ram_we    = |r_wstrb;
          end
          R_PROG: begin
            // A loader write wins; a CPU read waits so it returns the fresh word.
            if (!(ld_wen && r_wstrb == 4'b0)) begin
              w_done      = 1'b1;
              w_rdata_nxt = r_prog_q;
            end
          end
          R_STAT: begin
            w_done      = 1'b1;
            w_rdata_nxt = {31'b0, r_err_irq};
            w_err_clr   = |r_wstrb;
          end
          default: begin
            w_done      = 1'b1;
            w_rdata_nxt = 32'hDEAD_BEEF;
            w_err_set   = 1'b1;
          end
        endcase
        if (w_done) w_state_nxt = S_RESP;
      end
      S_IO_WAIT: begin
        if (io_ready[r_ch]) begin
          w_done      = 1'b1;
          w_io_end    = 1'b1;
          w_rdata_nxt = io_rdata[32*r_ch +: 32];
          w_state_nxt = S_RESP;
        end else if (r_cnt == 16'(TIMEOUT)) begin
          w_done      = 1'b1;
          w_io_end    = 1'b1;
          w_rdata_nxt = 32'hFFFF_FFFF;
          w_err_set   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking.
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cpu_ready <= 1'b0;
      r_io_valid  <= '0;
      r_err_irq   <= 1'b0;
      r_err_addr  <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_ready <= w_done;
      if (w_io_start)    r_io_valid <= w_dec_onehot;
      else if (w_io_end) r_io_valid <= '0;
      r_cnt <= (r_state == S_IO_WAIT) ? r_cnt + 16'd1 : '0;
      if (w_err_set && !r_err_irq) begin
        r_err_irq  <= 1'b1;
        r_err_addr <= r_addr;
      end else if (w_err_clr) begin
        r_err_irq  <= 1'b0;
      end
    end
  end

  // Request latches and read data carry no reset; they are only observed once qualified.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && cpu_valid) begin
      r_addr   <= cpu_addr;
      r_wdata  <= cpu_wdata;
      r_wstrb  <= cpu_wstrb;
      r_region <= w_dec_region;
      r_ch     <= w_dec_ch;
    end
    if (w_done) r_rdata <= w_rdata_nxt;
  end

  // NOTE: memory arrays are never reset; contents survive resetn and map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_ram[w_ram_widx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
    r_ram_q <= r_ram[w_ram_ridx];
  end

  always_ff @(posedge clk) begin
    if (w_ld_hit) r_prog[w_ld_idx] <= ld_wdata;
    r_prog_q <= (w_ld_hit && w_ld_idx == w_prog_ridx) ? ld_wdata : r_prog[w_prog_ridx];
  end

  assign cpu_ready = r_cpu_ready;
  assign cpu_rdata = r_rdata;
  assign io_valid  = r_io_valid;
  assign io_addr   = r_addr[IO_WIN_LOG2-1:0];
  assign io_wdata  = r_wdata;
  assign io_wstrb  = r_wstrb;
  assign err_irq   = r_err_irq;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_soc_mem_fabric.sv
// Randomized scoreboard bench for soc_mem_fabric: a driver pushes expected responses
// from an address-map reference model; a monitor pops them whenever cpu_ready pulses.
module tb_soc_mem_fabric;

  localparam int          RAM_WORDS  = 8192;
  localparam int          PROG_WORDS = 4096;
  localparam logic [31:0] PROG_BASE  = 32'h0010_0000;
  localparam int          IO_CH      = 4;
  localparam logic [31:0] IO_BASE    = 32'h0300_0000;
  localparam int          WIN_LOG2   = 20;
  localparam logic [31:0] STAT_ADDR  = 32'h0200_0010;
  localparam int          TIMEOUT    = 255;
  localparam logic [31:0] WIN        = 32'h1 << WIN_LOG2;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   cpu_valid, cpu_instr, cpu_ready;
  logic [31:0]            cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]             cpu_wstrb;
  logic [IO_CH-1:0]       io_valid, io_ready;
  logic [WIN_LOG2-1:0]    io_addr;
  logic [31:0]            io_wdata;
  logic [3:0]             io_wstrb;
  logic [32*IO_CH-1:0]    io_rdata;
  logic                   ld_wen;
  logic [31:0]            ld_waddr, ld_wdata;
  logic                   err_irq;
  logic [31:0]            err_addr;

  always #5 clk = ~clk;

  soc_mem_fabric #(
    .RAM_WORDS(RAM_WORDS), .PROG_WORDS(PROG_WORDS), .PROG_BASE(PROG_BASE),
    .IO_CH(IO_CH), .IO_BASE(IO_BASE), .IO_WIN_LOG2(WIN_LOG2),
    .STAT_ADDR(STAT_ADDR), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .io_valid(io_valid), .io_addr(io_addr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
    .io_ready(io_ready), .io_rdata(io_rdata),
    .ld_wen(ld_wen), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
    .err_irq(err_irq), .err_addr(err_addr)
  );

  typedef struct packed { logic [31:0] data; logic chk; } exp_t;
  typedef enum {K_RAM, K_PROG, K_STAT, K_IO, K_UNMAP} kind_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] ref_ram  [int];
  logic [31:0] ref_prog [int];
  logic        ref_err;
  logic [31:0] ref_err_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic kind_t classify(input logic [31:0] a, output int ch);
    ch = 0;
    if (a < 32'(4 * RAM_WORDS)) return K_RAM;
    if (a >= PROG_BASE && a < PROG_BASE + 32'(4 * PROG_WORDS)) return K_PROG;
    if (a == STAT_ADDR) return K_STAT;
    if (a >= IO_BASE && (a - IO_BASE) < 32'(IO_CH) * WIN) begin
      ch = int'((a - IO_BASE) / WIN);
      return K_IO;
    end
    return K_UNMAP;
  endfunction

  function automatic void model_err(input logic [31:0] a);
    if (!ref_err) begin
      ref_err      = 1'b1;
      ref_err_addr = a;
    end
  endfunction

  // Scoreboard monitor: every cpu_ready pulse consumes exactly one expected response.
  always @(negedge clk) begin
    if (resetn === 1'b1 && cpu_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got cpu_ready=1, expected no response (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk) check("rdata", cpu_rdata, mon_e.data);
      end
    end
  end

  task automatic ld_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_wen = 1'b1; ld_waddr = a; ld_wdata = d;
    @(negedge clk);
    ld_wen = 1'b0;
    if (a < 32'(4 * PROG_WORDS)) ref_prog[int'(a >> 2)] = d;
  endtask

  // io_lat: cycles after io_valid before io_ready (-1 = never). ld_at=1 pulses ld_wen in the MEM cycle.
  task automatic cpu_op(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int io_lat, input logic [31:0] io_data,
                        input int ld_at, input logic [31:0] ld_a, input logic [31:0] ld_d);
    kind_t       k;
    int          ch, lat, exp_lat;
    bit          seen;
    exp_t        e;
    logic [31:0] tmp;
    k = classify(addr, ch);
    if (ld_at == 1 && ld_a < 32'(4 * PROG_WORDS)) ref_prog[int'(ld_a >> 2)] = ld_d;
    e.chk   = (wstrb == 4'b0);
    e.data  = '0;
    exp_lat = 2;
    case (k)
      K_RAM: begin
        if (wstrb != 4'b0) begin
          tmp = ref_ram[int'(addr >> 2)];
          for (int b = 0; b < 4; b++) if (wstrb[b]) tmp[8*b +: 8] = wdata[8*b +: 8];
          ref_ram[int'(addr >> 2)] = tmp;
        end else begin
          e.data = ref_ram[int'(addr >> 2)];
        end
      end
      K_PROG: begin
        if (wstrb == 4'b0) begin
          e.data = ref_prog[int'((addr - PROG_BASE) >> 2)];
          if (ld_at == 1) exp_lat = 3;
        end
      end
      K_STAT: begin
        if (wstrb != 4'b0) ref_err = 1'b0;
        else e.data = {31'b0, ref_err};
      end
      K_IO: begin
        e.chk = 1'b1;
        if (io_lat >= 0 && io_lat <= TIMEOUT) begin
          e.data  = io_data;
          exp_lat = 2 + io_lat;
        end else begin
          e.data  = 32'hFFFF_FFFF;
          exp_lat = TIMEOUT + 2;
          model_err(addr);
        end
      end
      default: begin
        e.chk  = 1'b1;
        e.data = 32'hDEAD_BEEF;
        model_err(addr);
      end
    endcase
    exp_q.push_back(e);

    @(negedge clk);
    cpu_valid = 1'b1; cpu_instr = 1'($urandom); cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    lat = 0; seen = 1'b0;
    while (!seen && lat < TIMEOUT + 40) begin
      @(negedge clk);
      lat++;
      ld_wen   = (lat == ld_at);
      ld_waddr = ld_a;
      ld_wdata = ld_d;
      io_ready = '0;
      if (k == K_IO) begin
        if (lat == 1) begin
          check("io_valid", 32'(io_valid), 32'(1) << ch);
          check("io_addr", 32'(io_addr), addr & (WIN - 1));
          if (wstrb != 4'b0) begin
            check("io_wdata", io_wdata, wdata);
            check("io_wstrb", 32'(io_wstrb), 32'(wstrb));
          end
          if (io_lat > 1) io_ready[(ch + 1) % IO_CH] = 1'b1;
        end
        if (io_lat >= 0 && lat == 1 + io_lat) begin
          io_rdata = {$urandom, $urandom, $urandom, $urandom};
          io_rdata[32*ch +: 32] = io_data;
          io_ready[ch] = 1'b1;
        end
      end
      if (cpu_ready === 1'b1) seen = 1'b1;
    end
    cpu_valid = 1'b0; ld_wen = 1'b0; io_ready = '0;
    check("cpu_ready_seen", 32'(seen), 32'd1);
    if (!seen && exp_q.size() > 0) void'(exp_q.pop_back());
    check("latency", 32'(lat), 32'(exp_lat));
    check("err_irq", 32'(err_irq), 32'(ref_err));
    check("err_addr", err_addr, ref_err_addr);
    if (k == K_IO) check("io_valid_drop", 32'(io_valid), 32'd0);
  endtask

  task automatic rd(input logic [31:0] a);
    cpu_op(a, 32'h0, 4'h0, -1, 32'h0, -1, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cpu_op(a, d, s, -1, 32'h0, -1, 32'h0, 32'h0);
  endtask

  initial begin
    int          r, ch, seen_late;
    logic [31:0] a;
    resetn = 1'b0; cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_wstrb = '0; io_ready = '0; io_rdata = '0; ld_wen = 1'b0; ld_waddr = '0; ld_wdata = '0;
    ref_err = 1'b0; ref_err_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_cpu_ready", 32'(cpu_ready), 32'd0);
    check("reset_io_valid", 32'(io_valid), 32'd0);
    check("reset_err_irq", 32'(err_irq), 32'd0);
    check("reset_err_addr", err_addr, 32'd0);
    resetn = 1'b1;

    for (int w = 0; w < 64; w++) wr(32'(w * 4), $urandom, 4'hF);
    for (int w = 0; w < 32; w++) ld_write(32'(w * 4), $urandom);

    // Byte-strobe merge on RAM word 0x40.
    wr(32'h40, 32'h0, 4'hF);
    wr(32'h40, 32'h1234_5678, 4'b0101);
    rd(32'h40);

    // Loader write collides with a CPU PROG read of the same word.
    cpu_op(PROG_BASE + 32'h10, 32'h0, 4'h0, -1, 32'h0, 1, 32'h10, 32'hCAFE_F00D);
    // Out-of-range loader address must not alias onto word 0; CPU PROG writes are ignored.
    ld_write(32'(4 * PROG_WORDS), 32'h1BAD_BAD1);
    rd(PROG_BASE);
    wr(PROG_BASE + 32'h8, 32'hFFFF_0000, 4'hF);
    rd(PROG_BASE + 32'h8);

    // IO channel 2 read answered after 3 cycles, then an IO write on channel 0.
    cpu_op(IO_BASE + (32'd2 << WIN_LOG2) + 32'h8, 32'h0, 4'h0, 3, 32'hA5A5_0002, -1, 0, 0);
    cpu_op(IO_BASE + 32'h100, 32'h5566_7788, 4'b1100, 1, 32'h0BAD_F00D, -1, 0, 0);

    // Channel 1 never answers: timeout, then status read/clear.
    cpu_op(IO_BASE + (32'd1 << WIN_LOG2) + 32'h24, 32'h0, 4'h0, -1, 32'h0, -1, 0, 0);
    rd(STAT_ADDR);
    wr(STAT_ADDR, 32'h0, 4'h1);
    rd(STAT_ADDR);

    // Two unmapped reads: only the first address is captured.
    rd(32'h0400_0000);
    rd(32'h0500_0000);
    wr(STAT_ADDR, 32'h0, 4'hF);
    rd(STAT_ADDR);

    for (int i = 0; i < 90; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: cpu_op(32'($urandom_range(0, 63) * 4), $urandom,
                        ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                        -1, 0, ($urandom_range(0, 2) == 0) ? 1 : -1,
                        32'($urandom_range(0, 31) * 4), $urandom);
        3: cpu_op(PROG_BASE + 32'($urandom_range(0, 31) * 4), $urandom,
                  ($urandom_range(0, 3) == 0) ? 4'hF : 4'h0, -1, 0,
                  ($urandom_range(0, 1) == 0) ? 1 : -1, 32'($urandom_range(0, 31) * 4), $urandom);
        4: ld_write(($urandom_range(0, 7) == 0) ? 32'(4 * PROG_WORDS) + 32'($urandom_range(0, 31) * 4)
                                                : 32'($urandom_range(0, 31) * 4), $urandom);
        5: cpu_op(STAT_ADDR, 32'h0, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'h2, -1, 0, -1, 0, 0);
        6: cpu_op(($urandom_range(0, 1) == 0) ? 32'h0400_0000 + 32'($urandom_range(0, 4095) * 4)
                                              : 32'h0200_0014, 32'h0, 4'h0, -1, 0, -1, 0, 0);
        7, 8: begin
          ch = $urandom_range(0, IO_CH - 1);
          a  = IO_BASE + (32'(ch) << WIN_LOG2) + (32'($urandom) & (WIN - 4));
          cpu_op(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF,
                 $urandom_range(0, 8), $urandom, -1, 0, 0);
        end
        default: begin
          if ($urandom_range(0, 3) == 0)
            cpu_op(IO_BASE + (32'd3 << WIN_LOG2), 32'h0, 4'h0, -1, 0, -1, 0, 0);
          else
            rd(32'($urandom_range(0, 63) * 4));
        end
      endcase
    end

    // Reset while waiting on IO: the transaction is abandoned and a late io_ready is ignored.
    rd(32'h0600_0000);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = IO_BASE + (32'd1 << WIN_LOG2) + 32'h30; cpu_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    resetn = 1'b0; cpu_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    ref_err = 1'b0; ref_err_addr = '0;
    check("rst_io_valid", 32'(io_valid), 32'd0);
    check("rst_err_irq", 32'(err_irq), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    io_rdata[63:32] = 32'h1A7E_0001;
    io_ready[1] = 1'b1;
    seen_late = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) io_ready = '0;
      if (cpu_ready === 1'b1) seen_late = 1;
    end
    check("late_ready_ignored", 32'(seen_late), 32'd0);
    check("late_io_valid", 32'(io_valid), 32'd0);
    rd(32'h40);
    rd(32'h0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/soc_mem_fabric.md
# soc_mem_fabric

Parametrised memory fabric between the PicoRV32 native memory bus and the SoC's memories and peripherals. It provides:
- an internal byte-writable RAM;
- a program memory that an external loader can rewrite;
- IO_CH independent IO channels, each with its own address window;
- a bus-error status register.

Unmapped accesses and IO accesses that exceed the timeout complete with an error response instead of hanging the CPU.

## Interface
Parameters
- RAM_WORDS, 8192: internal RAM depth in 32-bit words. Byte range is 0 to 4*RAM_WORDS-1.
- PROG_WORDS, 4096: program memory depth in words.
- PROG_BASE, 32'h0010_0000: program memory byte base address.
- IO_CH, 4: number of IO channels (1..8).
- IO_BASE, 32'h0300_0000: base of channel 0.
- IO_WIN_LOG2, 20: log2 of each channel's window size in bytes. Channel k occupies IO_BASE + (k << IO_WIN_LOG2).
- STAT_ADDR, 32'h0200_0010: status register address.
- TIMEOUT, 255: maximum IO wait in cycles (1..65535).

Ports
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- cpu_valid/cpu_instr  in  1/1  CPU request; cpu_instr is ignored except for trace
- cpu_addr/cpu_wdata  in  32/32  CPU address, write data
- cpu_wstrb  in  4  byte strobes; 0 means read
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while cpu_ready is high
- io_valid  out  IO_CH  per-channel request, one-hot
- io_addr  out  IO_WIN_LOG2  offset inside the channel window
- io_wdata/io_wstrb  out  32/4  shared write data and strobes
- io_ready  in  IO_CH  per-channel completion
- io_rdata  in  32*IO_CH  channel k read data in bits [32k+31:32k]
- ld_wen  in  1  loader write enable
- ld_waddr/ld_wdata  in  32/32  loader byte address (relative to PROG_BASE) and data
- err_irq  out  1  sticky bus-error flag
- err_addr  out  32  address of the first error

## Operation
Decode priority, top to bottom:
- RAM
- PROG
- STAT
- IO channel k
- unmapped

States: IDLE, MEM, IO_WAIT, RESP.

IDLE
- On a cpu_valid sample, decode the address and latch address, data and strobes.
- RAM, PROG, STAT or unmapped → MEM.
- IO → IO_WAIT, with io_valid[k] set.

MEM
- Completes the access and pulses cpu_ready, then goes to RESP.
- RAM: a read returns the addressed word. A write updates only the bytes whose cpu_wstrb bit is set; its cpu_rdata is don't-care.
- PROG: a read returns the word. Writes from the CPU are ignored but still complete.
- STAT read: returns {31'b0, err_irq}.
- STAT write with any strobe set: clears err_irq. err_addr keeps its value.
- Unmapped: cpu_rdata = 32'hDEAD_BEEF. If err_irq = 0, set err_irq and capture err_addr.

IO_WAIT
- Counter starts at 0 and increments each cycle.
- io_ready[k] sampled high: latch io_rdata slice k, drop io_valid, pulse cpu_ready, → RESP.
- Counter reaches TIMEOUT without io_ready: drop io_valid, return cpu_rdata = 32'hFFFF_FFFF, apply the same error capture as unmapped, → RESP.
- io_ready from non-selected channels is ignored.

RESP
- One bubble cycle so the CPU can deassert cpu_valid. Always → IDLE.

Loader
- ld_wen writes PROG word ld_waddr[log2(PROG_WORDS)+1:2].
- The loader has priority. A CPU PROG read in the same cycle as ld_wen stays in MEM until ld_wen is low, then reads the updated data.
- ld_waddr outside the program memory range is ignored.

Reset (resetn low at a clock edge)
- State → IDLE; cpu_ready, io_valid, err_irq and err_addr all → 0; the IO counter clears.
- A pending IO transaction is abandoned, and a late io_ready is ignored.
- RAM and PROG contents are preserved.

## Timing
- Sampling edge E0 is when IDLE sees cpu_valid. For RAM, STAT or unmapped accesses, cpu_ready is high in the cycle after E0+1.
- PROG: same as RAM, plus one cycle per cycle that ld_wen is held.
- IO
  - io_valid is registered and goes high after E0.
  - If io_ready is sampled high at edge En, cpu_ready is high in the cycle after En and io_valid is low after En.
  - Timeout response: cpu_ready goes high TIMEOUT+1 cycles after io_valid rises.
- Throughput: back-to-back RAM accesses every 3 cycles (IDLE, MEM, RESP).
- cpu_rdata holds its value outside cpu_ready.

## Test plan
- Write 32'h1234_5678 to RAM 0x40 with wstrb 4'b0101, after 0 was stored there → readback 32'h0034_0078.
- ld_wen writes 32'hCAFE_F00D to relative address 0x10 while the CPU reads PROG_BASE+0x10 in the same cycle → CPU stalls one extra cycle, then returns 32'hCAFE_F00D.
- IO channel 2 read at IO_BASE+(2<<20)+0x8 with io_ready after 3 cycles and rdata 32'hA5A5_0002 → io_addr = 0x8, only io_valid[2] high, cpu_rdata = 32'hA5A5_0002, err_irq stays 0.
- IO channel 1 never answers, TIMEOUT = 255 → cpu_rdata = 32'hFFFF_FFFF at cycle 256, err_irq = 1, err_addr = the requested address.
- Read unmapped 0x0400_0000, then 0x0500_0000 → both return 32'hDEAD_BEEF and err_addr stays 0x0400_0000. A STAT write clears err_irq; a following STAT read returns 0.
- Assert resetn low during IO_WAIT, then assert a late io_ready → no cpu_ready, io_valid = 0, err_irq = 0, and the next RAM access works normally.
